// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue between the instruction ROM and the IF2ID stage.
// Issues sequential word fetches ahead of decode. It keeps a PC/instruction FIFO
// that absorbs ID back-pressure and variable ROM latency. A flush drops every
// queued entry and every response still in flight, then restarts fetch at the
// redirect address.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          asynchronous, active-low reset
//   rom_ce_o       fetch request valid this cycle
//   rom_addr_o     fetch address (word aligned, 0 when no request)
//   rom_rvalid_i   ROM response valid (in request order)
//   rom_rdata_i    instruction word of the oldest outstanding request
//   flush_i        drop queued/in-flight fetches, restart at redirect_pc_i
//   redirect_pc_i  restart address, bits [1:0] ignored
//   valid_o        head entry valid toward IF2ID
//   ready_i        ID accepts the head entry this cycle
//   pc_o / inst_o  head entry PC / instruction (0 when !valid_o)
//   count_o        occupied FIFO entries
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      rom_ce_o,
  output logic [31:0]               rom_addr_o,
  input  logic                      rom_rvalid_i,
  input  logic [31:0]               rom_rdata_i,
  input  logic                      flush_i,
  input  logic [31:0]               redirect_pc_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [31:0]               pc_o,
  output logic [31:0]               inst_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // Control state
  logic [31:0] r_fetch_pc, r_fetch_pc_d;
  logic [31:0] r_resp_pc,  r_resp_pc_d;
  cnt_t        r_count,    r_count_d;
  cnt_t        r_inflight, r_inflight_d;
  cnt_t        r_discard,  r_discard_d;
  ptr_t        r_wptr,     r_wptr_d;
  ptr_t        r_rptr,     r_rptr_d;

  // Entry storage, written only on a push
  logic [31:0] r_pc_mem   [DEPTH];
  logic [31:0] r_inst_mem [DEPTH];

  logic [CW:0] w_occ;
  logic        w_issue;
  logic        w_resp;
  logic        w_drop;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_redirect;

  // Queued plus outstanding entries never exceed DEPTH, so a push can never
  // find the FIFO full.
  assign w_occ      = {1'b0, r_count} + {1'b0, r_inflight};
  // rst_i gates the request so nothing is presented while reset is held.
  // The first request is then taken on the first edge after release.
  assign w_issue    = rst_i & ~flush_i & (w_occ < DEPTH_W);
  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_resp     = rom_rvalid_i & (r_inflight != '0);
  assign w_drop     = w_resp & (r_discard != '0);
  assign w_push     = w_resp & ~w_drop & ~flush_i;
  assign w_pop      = valid_o & ready_i & ~flush_i;
  assign w_redirect = {redirect_pc_i[31:2], 2'b00};

  always_comb begin
    r_fetch_pc_d = r_fetch_pc;
    r_resp_pc_d  = r_resp_pc;
    r_count_d    = r_count;
    r_inflight_d = r_inflight;
    r_discard_d  = r_discard;
    r_wptr_d     = r_wptr;
    r_rptr_d     = r_rptr;

    if (flush_i) begin
      r_fetch_pc_d = w_redirect;
      r_resp_pc_d  = w_redirect;
      r_count_d    = '0;
      r_wptr_d     = '0;
      r_rptr_d     = '0;
      // Every outstanding request becomes stale. Requests already marked for
      // discard are part of r_inflight, so the new discard count is just
      // what remains in flight after this cycle's response.
      r_inflight_d = r_inflight - cnt_t'(w_resp);
      r_discard_d  = r_inflight - cnt_t'(w_resp);
    end else begin
      if (w_issue) begin
        r_fetch_pc_d = r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_resp_pc_d = r_resp_pc + 32'd4;
        r_wptr_d    = r_wptr + ptr_t'(1);
      end
      if (w_pop) begin
        r_rptr_d = r_rptr + ptr_t'(1);
      end
      r_count_d    = r_count + cnt_t'(w_push) - cnt_t'(w_pop);
      r_inflight_d = r_inflight + cnt_t'(w_issue) - cnt_t'(w_resp);
      r_discard_d  = r_discard - cnt_t'(w_drop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_fetch_pc <= r_fetch_pc_d;
      r_resp_pc  <= r_resp_pc_d;
      r_count    <= r_count_d;
      r_inflight <= r_inflight_d;
      r_discard  <= r_discard_d;
      r_wptr     <= r_wptr_d;
      r_rptr     <= r_rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= r_resp_pc;
      r_inst_mem[r_wptr] <= rom_rdata_i;
    end
  end

  assign rom_ce_o   = w_issue;
  assign rom_addr_o = w_issue ? r_fetch_pc : 32'h0;
  assign valid_o    = (r_count != '0);
  assign pc_o       = valid_o ? r_pc_mem[r_rptr]   : 32'h0;
  assign inst_o     = valid_o ? r_inst_mem[r_rptr] : 32'h0;
  assign count_o    = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue. The bench ROM and a transaction-level model
// are kept as queues: one of outstanding requests, with a stale mark, and
// one of delivered entries. Every cycle all DUT outputs are compared with
// what the model predicts. Scenario tasks add explicit checks of
// documented behaviour.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic        rom_rvalid_i;
  logic [31:0] rom_rdata_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [2:0]  count_o;

  inst_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rom_ce_o      (rom_ce_o),
    .rom_addr_o    (rom_addr_o),
    .rom_rvalid_i  (rom_rvalid_i),
    .rom_rdata_i   (rom_rdata_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        out_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_fetch_pc;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          vectors = 0;
  int          miscompares = 0;

  // Outputs observed in the most recent step
  logic        obs_ce, obs_valid;
  logic [31:0] obs_addr, obs_pc;
  logic [2:0]  obs_count;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5C3_1E69;
  endfunction

  task automatic model_reset();
    out_q.delete();
    fifo_q.delete();
    m_fetch_pc = RESET_PC;
  endtask

  // One clock cycle: drive at negedge, check, advance model, wait posedge.
  task automatic step(input bit fl, input logic [31:0] rpc, input bit rdy, input bit stray);
    bit          rv, exp_ce, pop;
    logic [2:0]  exp_cnt;
    req_t        r;
    int          d;
    @(negedge clk_i);
    rv            = (out_q.size() > 0) && (out_q[0].due <= cyc);
    flush_i       = fl;
    redirect_pc_i = rpc;
    ready_i       = rdy;
    rom_rvalid_i  = rv | (stray && out_q.size() == 0);
    rom_rdata_i   = rv ? rom_word(out_q[0].addr) : $urandom();
    #1;
    obs_ce    = rom_ce_o;
    obs_addr  = rom_addr_o;
    obs_valid = valid_o;
    obs_pc    = pc_o;
    obs_count = count_o;

    exp_ce  = !fl && (fifo_q.size() + out_q.size() < DEPTH);
    exp_cnt = 3'(fifo_q.size());
    vectors++;
    if (rom_ce_o !== exp_ce) begin
      miscompares++;
      $display("FAIL rom_ce cyc=%0d: got %b expected %b", cyc, rom_ce_o, exp_ce);
    end
    if (exp_ce) begin
      vectors++;
      if (rom_addr_o !== m_fetch_pc) begin
        miscompares++;
        $display("FAIL rom_addr cyc=%0d: got %h expected %h", cyc, rom_addr_o, m_fetch_pc);
      end
    end
    vectors++;
    if (count_o !== exp_cnt) begin
      miscompares++;
      $display("FAIL count cyc=%0d: got %0d expected %0d", cyc, count_o, exp_cnt);
    end
    vectors++;
    if (valid_o !== (fifo_q.size() > 0)) begin
      miscompares++;
      $display("FAIL valid cyc=%0d: got %b expected %b", cyc, valid_o, fifo_q.size() > 0);
    end
    vectors++;
    if (fifo_q.size() > 0) begin
      if (pc_o !== fifo_q[0].pc || inst_o !== fifo_q[0].inst) begin
        miscompares++;
        $display("FAIL head cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                 cyc, pc_o, inst_o, fifo_q[0].pc, fifo_q[0].inst);
      end
    end else if (pc_o !== 32'h0 || inst_o !== 32'h0) begin
      miscompares++;
      $display("FAIL idle_head cyc=%0d: got pc=%h inst=%h expected 0", cyc, pc_o, inst_o);
    end

    pop = !fl && rdy && (fifo_q.size() > 0);
    if (fl) begin
      if (rv) void'(out_q.pop_front());
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      fifo_q.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (pop) void'(fifo_q.pop_front());
      if (rv) begin
        r = out_q.pop_front();
        if (!r.stale) fifo_q.push_back('{pc: r.addr, inst: rom_word(r.addr)});
      end
      if (exp_ce) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (out_q.size() > 0 && out_q[$].due >= d) d = out_q[$].due + 1;
        out_q.push_back('{addr: m_fetch_pc, stale: 1'b0, due: d});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk_i);
    cyc++;
  endtask

  task automatic release_reset();
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_i = 1'b0; flush_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b0;
    rom_rvalid_i = 1'b0; rom_rdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if ({rom_ce_o, valid_o} !== 2'b00 || count_o !== 3'd0 || rom_addr_o !== 32'h0 ||
        pc_o !== 32'h0 || inst_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ce=%b addr=%h valid=%b pc=%h inst=%h cnt=%0d expected all 0",
               rom_ce_o, rom_addr_o, valid_o, pc_o, inst_o, count_o);
    end
    release_reset();
  endtask

  task automatic test_stream();
    int n_valid = 0;
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (k == 0) begin
        vectors++;
        if (obs_ce !== 1'b1 || obs_addr !== 32'hBFC0_0000) begin
          miscompares++;
          $display("FAIL first_fetch: got ce=%b addr=%h expected 1 BFC00000", obs_ce, obs_addr);
        end
      end
      if (k == 1) begin
        vectors++;
        if (obs_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL early_valid: got %b expected 0", obs_valid);
        end
      end
      if (k == 2) begin
        vectors++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'hBFC0_0000) begin
          miscompares++;
          $display("FAIL first_valid: got valid=%b pc=%h expected 1 BFC00000", obs_valid, obs_pc);
        end
      end
      if (k >= 4 && obs_valid === 1'b1) n_valid++;
    end
    vectors++;
    if (n_valid != 16) begin
      miscompares++;
      $display("FAIL throughput: got %0d expected 16 valid cycles", n_valid);
    end
  endtask

  task automatic test_backpressure();
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (obs_count !== 3'd4 || obs_ce !== 1'b0) begin
      miscompares++;
      $display("FAIL saturate: got count=%0d ce=%b expected 4 0", obs_count, obs_ce);
    end
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_inflight();
    int  guard = 0;
    bit  seen = 1'b0;
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    while (out_q.size() < 3 && guard < 30) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b1, 32'h8000_0100, 1'b1, 1'b0);
    for (int k = 0; k < 30 && !seen; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_valid === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (obs_pc !== 32'h8000_0100) begin
          miscompares++;
          $display("FAIL flush_first_pc: got %h expected 80000100", obs_pc);
        end
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL flush_first_pc: got no valid within 30 cycles expected pc 80000100");
    end
  endtask

  task automatic test_flush_collide();
    int guard = 0;
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    while (!(out_q.size() > 0 && out_q[0].due <= cyc && fifo_q.size() > 0) && guard < 20) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b1, 32'h0000_2003, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    vectors++;
    if (obs_count !== 3'd0 || obs_ce !== 1'b1 || obs_addr !== 32'h0000_2000) begin
      miscompares++;
      $display("FAIL collide: got count=%0d ce=%b addr=%h expected 0 1 00002000",
               obs_count, obs_ce, obs_addr);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [4];
    int          n = 0;
    exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    lat_min = 2; lat_max = 2;
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
    for (int k = 0; k < 20 && n < 4; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      if (obs_ce === 1'b1) begin
        vectors++;
        if (obs_addr !== exp_w[n]) begin
          miscompares++;
          $display("FAIL wrap_addr%0d: got %h expected %h", n, obs_addr, exp_w[n]);
        end
        n++;
      end
    end
    if (n < 4) begin
      vectors++;
      miscompares++;
      $display("FAIL wrap_count: got %0d fetches expected 4", n);
    end
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midstream();
    int guard = 0;
    lat_min = 3; lat_max = 3;
    while (out_q.size() < 2 && guard < 30) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      guard++;
    end
    #3 rst_i = 1'b0;
    #1;
    vectors++;
    if ({rom_ce_o, valid_o} !== 2'b00 || count_o !== 3'd0 || rom_addr_o !== 32'h0 ||
        pc_o !== 32'h0 || inst_o !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got ce=%b addr=%h valid=%b pc=%h cnt=%0d expected all 0",
               rom_ce_o, rom_addr_o, valid_o, pc_o, count_o);
    end
    repeat (2) @(posedge clk_i);
    release_reset();
    // Late response from before reset while nothing is outstanding
    step(1'b0, 32'h0, 1'b1, 1'b1);
    vectors++;
    if (obs_ce !== 1'b1 || obs_addr !== 32'hBFC0_0000) begin
      miscompares++;
      $display("FAIL restart_addr: got ce=%b addr=%h expected 1 BFC00000", obs_ce, obs_addr);
    end
    for (int k = 0; k < 12; k++) step(1'b0, 32'h0, ($urandom_range(3, 0) != 0), 1'b0);
  endtask

  task automatic test_random();
    bit          fl;
    logic [31:0] rpc;
    lat_min = 1; lat_max = 4;
    for (int k = 0; k < 400; k++) begin
      fl  = ($urandom_range(24, 0) == 0);
      rpc = $urandom();
      step(fl, rpc, ($urandom_range(9, 0) < 7), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_inflight();
    test_flush_collide();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
